tone_pwm_driver: RTL and testbench
==================================

// Module: tone_pwm_driver
// PURPOSE
//  Consumer end of the oscillator tick interface. Turns the 1-cycle at_max ticks into a
//  50% square wave, then scales it by an envelope: sustain, then linear decay.
//  Drives the speaker pin as PWM. Sits between the oscillator and the top-level audio pad.
//  note_start = goodColl | badColl.
// PARAMETERS
//  PWM_BITS    8      PWM counter / envelope width; ENV_MAX = 2**PWM_BITS-1
//  GAP_CYCLES  512    cycles with no at_max tick before SUSTAIN->DECAY (> max osc period 189)
//  DECAY_DIV   12000  cycles per envelope decrement (1 ms @ 12 MHz; 10000 on final chip)
// PORTS
//  clk         in   1         system clock (12 MHz FPGA / 10 MHz chip)
//  nRst        in   1         asynchronous, active-low reset
//  at_max      in   1         1-cycle tick from oscillator; one tick = one half-period
//  note_start  in   1         1-cycle pulse; (re)starts a note at full envelope
//  mute        in   1         level; forces speaker low; internal state keeps running
//  speaker     out  1         registered PWM audio output
//  square      out  1         raw square wave, before the envelope is applied
//  envelope    out  PWM_BITS  current amplitude
//  busy        out  1         1 when state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE; speaker=0, square=0, envelope=0, busy=0; all counters=0.
//  Square wave:
//   - square toggles on every at_max pulse while state != IDLE.
//   - square is forced to 0 on entry to IDLE.
//   - at_max arriving in IDLE is ignored.
//  State machine (audio_state_t):
//   IDLE    -> SUSTAIN  on note_start. envelope<=ENV_MAX, gap_cnt<=0, dec_cnt<=0.
//   SUSTAIN: envelope held at ENV_MAX.
//            gap_cnt clears on at_max, else +1.
//            gap_cnt==GAP_CYCLES-1 with no at_max that cycle -> DECAY, dec_cnt<=0.
//   DECAY:   dec_cnt+1 each cycle.
//            dec_cnt==DECAY_DIV-1 -> dec_cnt<=0, envelope<=envelope-1.
//            Decrement that makes envelope 0 -> IDLE (same edge).
//            at_max is still honoured (square keeps toggling while tail rings).
//   note_start in any state (incl. DECAY, SUSTAIN) -> SUSTAIN with full reload as above.
//  PWM:
//   - pwm_cnt: free-running PWM_BITS counter, wraps 2**PWM_BITS-1 -> 0.
//   - duty = square ? envelope : 0.
//   - speaker <= (pwm_cnt < duty) & ~mute. Registered: 1-cycle latency after pwm_cnt/duty.
//   - ENV_MAX gives 255/256 high; envelope 0 gives constant 0 (no glitch pulse).
//  Simultaneous events:
//   - note_start + at_max same cycle: both apply (reload AND toggle).
//   - at_max on the GAP_CYCLES-1 cycle: gap_cnt clears; stay in SUSTAIN.
//   - note_start on the final decrement cycle: SUSTAIN wins, envelope=ENV_MAX.
//  Arithmetic:
//   - envelope never underflows (decrement only while >0).
//   - gap_cnt width $clog2(GAP_CYCLES+1); dec_cnt width $clog2(DECAY_DIV).
//   - Comparisons unsigned.
//  Reset mid-note: immediate return to reset values; no tail.
// STRUCTURE
//  audio_pkg:
//   - typedef enum logic[1:0] {A_IDLE, A_SUSTAIN, A_DECAY} audio_state_t
//   - localparams: GOOD_FREQ=48, BAD_FREQ=188, FPGA/chip clock constants, shared with oscillator
//  Sub-module pwm_gen #(PWM_BITS):
//   - inputs: clk, nRst, duty, en
//   - output: pwm (owns pwm_cnt and the output register)
//  Top module: FSM, envelope, gap/decay counters, square flop.
// TESTING (bench overrides GAP_CYCLES=16, DECAY_DIV=4, PWM_BITS=4)
//  1. Reset, then at_max every 5 cycles with no note_start -> square=0, busy=0, speaker=0 throughout.
//  2. note_start, then at_max every 10 cycles ->
//     square toggles per tick; envelope=15; speaker high 15 of 16 cycles while square=1.
//  3. Stop ticks after (2) -> DECAY 16 cycles after last tick;
//     envelope 15->0 in 60 cycles; then IDLE, busy=0, square=0.
//  4. note_start while envelope=7 in DECAY -> next cycle envelope=15, state SUSTAIN, dec_cnt=0.
//  5. mute=1 during (2) -> speaker=0 while envelope/square still evolve;
//     mute=0 -> PWM resumes 1 cycle later.
//  6. nRst asserted mid-DECAY (envelope=9) -> all outputs 0 asynchronously;
//     after release busy=0 until next note_start.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared audio definitions: envelope state encoding and the tone/clock constants
// also used by the oscillator.
package audio_pkg;

    typedef enum logic [1:0] {
        A_IDLE,
        A_SUSTAIN,
        A_DECAY
    } audio_state_t;

    localparam int unsigned GOOD_FREQ   = 48;
    localparam int unsigned BAD_FREQ    = 188;
    localparam int unsigned FPGA_CLK_HZ = 12_000_000;
    localparam int unsigned CHIP_CLK_HZ = 10_000_000;

endpackage

// File: rtl/tone_pwm_driver_pwm_gen.sv
// Free-running PWM counter with a registered compare output; en gates the pin
// without disturbing the counter phase.
module pwm_gen #(
    parameter int unsigned PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                nRst,
    input  logic [PWM_BITS-1:0] duty,
    input  logic                en,
    output logic                pwm
);

    logic [PWM_BITS-1:0] cnt_q;
    logic                pwm_q;

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            cnt_q <= '0;
            pwm_q <= 1'b0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
            // duty of 0 never matches, so a silent envelope gives a flat-low pin
            pwm_q <= (cnt_q < duty) & en;
        end
    end

    assign pwm = pwm_q;

endmodule

// File: rtl/tone_pwm_driver.sv
// Square-wave tone shaper: toggles on oscillator ticks, applies a sustain/linear-decay
// envelope and drives the speaker pin through PWM.
module tone_pwm_driver
    import audio_pkg::*;
#(
    parameter int unsigned PWM_BITS   = 8,
    parameter int unsigned GAP_CYCLES = 512,
    parameter int unsigned DECAY_DIV  = 12000
) (
    input  logic                clk,
    input  logic                nRst,
    input  logic                at_max,
    input  logic                note_start,
    input  logic                mute,
    output logic                speaker,
    output logic                square,
    output logic [PWM_BITS-1:0] envelope,
    output logic                busy
);

    localparam int unsigned GW = $clog2(GAP_CYCLES + 1);
    localparam int unsigned DW = $clog2(DECAY_DIV);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
    localparam logic [DW-1:0] DEC_LAST = DW'(DECAY_DIV - 1);

    audio_state_t        state_q;
    logic [PWM_BITS-1:0] env_q;
    logic [GW-1:0]       gap_q;
    logic [DW-1:0]       dec_q;
    logic                square_q;
    logic [PWM_BITS-1:0] duty;

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q  <= A_IDLE;
            env_q    <= '0;
            gap_q    <= '0;
            dec_q    <= '0;
            square_q <= 1'b0;
        end else begin
            if (at_max && (state_q != A_IDLE || note_start))
                square_q <= ~square_q;

            if (note_start) begin
                state_q <= A_SUSTAIN;
                env_q   <= '1;
                gap_q   <= '0;
                dec_q   <= '0;
            end else begin
                case (state_q)
                    A_SUSTAIN: begin
                        if (at_max)
                            gap_q <= '0;
                        else if (gap_q == GAP_LAST) begin
                            state_q <= A_DECAY;
                            dec_q   <= '0;
                        end else
                            gap_q <= gap_q + 1'b1;
                    end
                    A_DECAY: begin
                        if (dec_q == DEC_LAST) begin
                            dec_q <= '0;
                            if (env_q != '0) begin
                                env_q <= env_q - 1'b1;
                                // last step overrides any tick this cycle
                                if (env_q == PWM_BITS'(1)) begin
                                    state_q  <= A_IDLE;
                                    square_q <= 1'b0;
                                end
                            end
                        end else
                            dec_q <= dec_q + 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign duty     = square_q ? env_q : '0;
    assign square   = square_q;
    assign envelope = env_q;
    assign busy     = (state_q != A_IDLE);

    pwm_gen #(.PWM_BITS(PWM_BITS)) u_pwm (
        .clk  (clk),
        .nRst (nRst),
        .duty (duty),
        .en   (~mute),
        .pwm  (speaker)
    );

endmodule

// File: tb/tb_tone_pwm_driver.sv
// Randomized bench for tone_pwm_driver against a timing-level reference model
// (envelope derived from elapsed decay time, pin from elapsed cycles).
module tb_tone_pwm_driver;

    localparam int PB   = 4;
    localparam int GAP  = 16;
    localparam int DIV  = 4;
    localparam int EMAX = 15;
    localparam int PER  = 16;

    logic          clk = 1'b0;
    logic          nRst = 1'b0;
    logic          at_max = 1'b0;
    logic          note_start = 1'b0;
    logic          mute = 1'b0;
    logic          speaker, square, busy;
    logic [PB-1:0] envelope;

    tone_pwm_driver #(.PWM_BITS(PB), .GAP_CYCLES(GAP), .DECAY_DIV(DIV)) dut (
        .clk        (clk),
        .nRst       (nRst),
        .at_max     (at_max),
        .note_start (note_start),
        .mute       (mute),
        .speaker    (speaker),
        .square     (square),
        .envelope   (envelope),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // model: mode 0 idle, 1 sustain, 2 decay
    int m_mode, m_gap, m_age, m_env, m_edges;
    bit m_sq, m_spk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_gap = 0; m_age = 0; m_env = 0; m_edges = 0;
        m_sq = 0; m_spk = 0;
    endtask

    task automatic model_edge(input bit ns, input bit am, input bit mu);
        int duty;
        bit was_active;
        duty = m_sq ? m_env : 0;
        m_spk = ((m_edges % PER) < duty) && !mu;
        m_edges++;
        was_active = (m_mode != 0);
        if (am && (was_active || ns)) m_sq = !m_sq;
        if (ns) begin
            m_mode = 1; m_gap = 0; m_age = 0; m_env = EMAX;
        end else if (m_mode == 1) begin
            if (am) m_gap = 0;
            else if (m_gap == GAP - 1) begin m_mode = 2; m_age = 0; end
            else m_gap++;
        end else if (m_mode == 2) begin
            m_age++;
            m_env = EMAX - m_age / DIV;
            if (m_env == 0) begin m_mode = 0; m_sq = 0; end
        end
    endtask

    task automatic step(input bit ns, input bit am, input bit mu);
        note_start = ns; at_max = am; mute = mu;
        @(posedge clk);
        model_edge(ns, am, mu);
        #1;
        check_eq("square", square, m_sq);
        check_eq("envelope", envelope, m_env);
        check_eq("busy", busy, m_mode != 0);
        check_eq("speaker", speaker, m_spk);
    endtask

    initial begin
        int cnt;
        bit mu;
        model_reset();
        #3;
        check_eq("rst_speaker", speaker, 0);
        check_eq("rst_square", square, 0);
        check_eq("rst_envelope", envelope, 0);
        check_eq("rst_busy", busy, 0);
        @(negedge clk);
        nRst = 1'b1;

        // ticks while idle are ignored
        for (int i = 0; i < 40; i++) step(0, (i % 5) == 4, 0);

        // note with regular ticks; mute window in the middle
        step(1, 0, 0);
        for (int i = 1; i <= 90; i++) step(0, (i % 10) == 0, (i >= 40 && i < 56));

        // ticks stop right after the tick on i=90: 16 gap cycles then 60 decay cycles
        cnt = 0;
        while (busy && cnt < 200) begin
            step(0, 0, 0);
            cnt++;
        end
        check_eq("tail_len", cnt, GAP + EMAX * DIV);
        check_eq("tail_square", square, 0);

        // restart while decaying at envelope 7
        step(1, 0, 0);
        for (int i = 1; i <= 30; i++) step(0, (i % 7) == 0, 0);
        cnt = 0;
        while (!(m_mode == 2 && m_env == 7) && cnt < 200) begin
            step(0, 0, 0);
            cnt++;
        end
        check_eq("reach_env7", envelope, 7);
        step(1, 0, 0);
        check_eq("restart_env", envelope, EMAX);
        cnt = 0;
        while (m_mode != 2 && cnt < 100) begin
            step(0, 0, 0);
            cnt++;
        end
        check_eq("restart_gap", cnt, GAP);

        // randomized segments
        mu = 0;
        for (int seg = 0; seg < 8; seg++) begin
            int rate;
            rate = $urandom_range(0, 25);
            for (int i = 0; i < 100; i++) begin
                if ($urandom_range(0, 39) == 0) mu = !mu;
                step($urandom_range(0, 119) == 0, $urandom_range(0, 99) < rate, mu);
            end
        end

        // asynchronous reset mid-decay at envelope 9
        step(1, 1, 0);
        cnt = 0;
        while (!(m_mode == 2 && m_env == 9) && cnt < 200) begin
            step(0, 0, 0);
            cnt++;
        end
        check_eq("reach_env9", envelope, 9);
        #2 nRst = 1'b0;
        #1;
        check_eq("arst_speaker", speaker, 0);
        check_eq("arst_square", square, 0);
        check_eq("arst_envelope", envelope, 0);
        check_eq("arst_busy", busy, 0);
        @(negedge clk);
        nRst = 1'b1;
        model_reset();
        for (int i = 0; i < 30; i++) step(0, (i % 3) == 0, 0);
        step(1, 0, 0);
        check_eq("post_rst_busy", busy, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
